// File: rtl/pattern_gen_pkg.sv
// Shared types and the LFSR tap table for the pattern_gen stimulus source.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        WALK  = 2'd1,
        LFSR  = 2'd2,
        CONST = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Maximal-length Fibonacci tap masks; bit n-1 set for tap n.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] m;
        m = '0;
        case (width)
            2:  m = 32'h0000_0003;
            3:  m = 32'h0000_0006;
            4:  m = 32'h0000_000C;
            5:  m = 32'h0000_0014;
            6:  m = 32'h0000_0030;
            7:  m = 32'h0000_0060;
            8:  m = 32'h0000_00B8;
            9:  m = 32'h0000_0110;
            10: m = 32'h0000_0240;
            11: m = 32'h0000_0500;
            12: m = 32'h0000_0829;
            13: m = 32'h0000_100D;
            14: m = 32'h0000_2015;
            15: m = 32'h0000_6000;
            16: m = 32'h0000_D008;
            17: m = 32'h0001_2000;
            18: m = 32'h0002_0400;
            19: m = 32'h0004_0023;
            20: m = 32'h0009_0000;
            21: m = 32'h0014_0000;
            22: m = 32'h0030_0000;
            23: m = 32'h0042_0000;
            24: m = 32'h00E1_0000;
            25: m = 32'h0120_0000;
            26: m = 32'h0200_0023;
            27: m = 32'h0400_0013;
            28: m = 32'h0900_0000;
            29: m = 32'h1400_0000;
            30: m = 32'h2000_0029;
            31: m = 32'h4800_0000;
            32: m = 32'h8020_0003;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// WIDTH-bit Fibonacci LFSR with synchronous load (zero seed forced to 1) and step.
module pattern_lfsr
    import pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr_out
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q;

endmodule

// File: rtl/pattern_gen.sv
// Burst pattern generator on a valid/ready stream with programmable word divider.
// Optional PATTERN_GEN_SIG_EN adds a rotate-XOR signature of accepted words on sig.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] div,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
`ifdef PATTERN_GEN_SIG_EN
    ,
    output logic [WIDTH-1:0] sig
`endif
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef PATTERN_GEN_SIG_EN
    logic [WIDTH-1:0] sig_q, sig_d;
`endif

    logic             stall, hs, tick, load_word, start_go;
    logic             lfsr_load, lfsr_step;
    logic [WIDTH-1:0] lfsr_word, word;

    pattern_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .seed     (seed),
        .lfsr_out (lfsr_word)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        len_d       = len_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        tick_d      = tick_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
`ifdef PATTERN_GEN_SIG_EN
        sig_d       = sig_q;
`endif
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;
        tick        = 1'b0;
        load_word   = 1'b0;
        stall       = out_valid_q && !out_ready;
        hs          = out_valid_q && out_ready;
        start_go    = start && !stop;
        word        = (mode_q == LFSR) ? lfsr_word : cur_q;

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    mode_d    = mode_e'(mode);
                    seed_d    = seed;
                    len_d     = len;
                    div_d     = div;
                    cnt_d     = '0;
                    idx_d     = '0;
                    tick_d    = 1'b0;
                    last_d    = 1'b0;
                    cur_d     = (mode_e'(mode) == WALK) ? WIDTH'(1) : seed;
                    lfsr_load = 1'b1;
`ifdef PATTERN_GEN_SIG_EN
                    sig_d     = '0;
`endif
                    state_d   = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // tick_q is the word staged for out_data; it survives a stall so no word is lost
                tick      = !stall && (cnt_q == div_q) && (idx_q != len_q);
                load_word = tick_q && !stall;
                if (!stall) begin
                    cnt_d = (cnt_q == div_q) ? '0 : cnt_q + 1'b1;
                end
                if (tick) begin
                    idx_d = idx_q + 1'b1;
                end
                tick_d = tick || (tick_q && stall);
                if (load_word) begin
                    out_valid_d = 1'b1;
                    out_data_d  = word;
                    last_d      = (idx_q == len_q);
                    lfsr_step   = (mode_q == LFSR);
                    case (mode_q)
                        COUNT:   cur_d = cur_q + 1'b1;
                        WALK:    cur_d = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
                        default: cur_d = cur_q;
                    endcase
                end else if (hs) begin
                    out_valid_d = 1'b0;
                end
`ifdef PATTERN_GEN_SIG_EN
                if (hs) begin
                    sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ out_data_q;
                end
`endif
                if (hs && last_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            tick_d      = 1'b0;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= COUNT;
            seed_q      <= '0;
            len_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            tick_q      <= 1'b0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PATTERN_GEN_SIG_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            len_q       <= len_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            tick_q      <= tick_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PATTERN_GEN_SIG_EN
            sig_q       <= sig_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef PATTERN_GEN_SIG_EN
    assign sig       = sig_q;
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Randomized self-checking bench for pattern_gen against a word-list and timing-rule model.
module tb_pattern_gen;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [1:0] mode;
    logic [9:0] seed;
    logic [7:0] len;
    logic [7:0] div;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       busy, done;
`ifdef PATTERN_GEN_SIG_EN
    logic [9:0] sig;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    pattern_gen #(.WIDTH(10), .LEN_W(8), .DIV_W(8)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .seed      (seed),
        .len       (len),
        .div       (div),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
`ifdef PATTERN_GEN_SIG_EN
        ,
        .sig       (sig)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // x^10 + x^7 + 1 shift-left Fibonacci step
    function automatic logic [9:0] lfsr_next(input logic [9:0] x);
        int unsigned v, fb;
        v  = 32'(x);
        fb = ((v >> 9) ^ (v >> 6)) & 1;
        return 10'(((v << 1) | fb) & 32'h3FF);
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] x);
        int unsigned v;
        v = 32'(x);
        return 10'(((v << 1) | (v >> 9)) & 32'h3FF);
    endfunction

    task automatic tick_cycle();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // rmode: 0 ready held high, 1 random ready, 2 five-cycle stall on word 1
    task automatic run_burst(input int m, input logic [9:0] sd, input int ln, input int dv,
                             input int rmode, input bit poke);
        logic [9:0] q[$];
        logic [9:0] x, d, pd, exp_w, msig;
        int         c, last_hs, n_hs, first_c, ns_cnt, stall_used;
        bit         v, r, pv, pr, appear;

        x = (sd == 10'd0) ? 10'd1 : sd;
        for (int i = 0; i < ln; i++) begin
            case (m)
                0: q.push_back(10'(32'(sd) + i));
                1: q.push_back(10'(1 << (i % 10)));
                2: begin q.push_back(x); x = lfsr_next(x); end
                default: q.push_back(sd);
            endcase
        end

        start = 1'b1; mode = 2'(m); seed = sd; len = 8'(ln); div = 8'(dv);
        out_ready = 1'b1;
        tick_cycle();
        start = 1'b0;
        mode = 2'($urandom); seed = 10'($urandom); len = 8'($urandom); div = 8'($urandom);

        if (ln == 0) begin
            check_eq("zero_done", done, 1);
            check_eq("zero_busy", busy, 0);
            check_eq("zero_valid", out_valid, 0);
            tick_cycle();
            check_eq("zero_done_clr", done, 0);
            check_eq("zero_valid2", out_valid, 0);
            return;
        end

        c = 0; last_hs = -10; n_hs = 0; first_c = -1; ns_cnt = 0; stall_used = 0;
        pv = 0; pr = 0; pd = '0; msig = '0;
        forever begin
            v = out_valid;
            d = out_data;
            case (rmode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = !(v && n_hs == 1 && stall_used < 5);
            endcase
            if (rmode == 2 && v && !r) stall_used++;
            out_ready = r;
            start = (poke && c == 1);

            if (pv && !pr) begin
                check_eq("hold_valid", v, 1);
                check_eq("hold_data", d, pd);
            end
            appear = v && !(pv && !pr);
            if (appear) begin
                if (first_c < 0) begin
                    first_c = c;
                    check_eq("first_latency", c, dv + 2);
                end else begin
                    check_eq("word_spacing", ns_cnt, dv + 1);
                end
                ns_cnt = 0;
            end
            if (v && r) begin
                check_eq("word_avail", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_w = q.pop_front();
                    check_eq("data", d, exp_w);
                    msig = rotl(msig) ^ d;
                    if (q.size() == 0) last_hs = c;
                end
                n_hs++;
            end
            check_eq("done", done, c == last_hs + 1);
            check_eq("busy", busy, (last_hs < 0) || (c <= last_hs));
            if (!(v && !r)) ns_cnt++;
            pv = v; pr = r; pd = d;

            if (last_hs >= 0 && c == last_hs + 2) break;
            if (c > 3000) begin
                check_eq("burst_timeout", c, 0);
                break;
            end
            tick_cycle();
            c++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check_eq("word_count", n_hs, ln);
`ifdef PATTERN_GEN_SIG_EN
        check_eq("sig", sig, msig);
`endif
    endtask

    task automatic stop_test();
        int n, c;
        start = 1'b1; mode = 2'd3; seed = 10'h155; len = 8'd8; div = 8'd0; out_ready = 1'b1;
        tick_cycle();
        start = 1'b0;
        n = 0; c = 0;
        while (n < 2 && c < 50) begin
            if (out_valid) begin
                check_eq("stop_data", out_data, 10'h155);
                n++;
            end
            tick_cycle();
            c++;
        end
        check_eq("stop_reached_word2", n, 2);
        check_eq("stop_word2_valid", out_valid, 1);
        stop = 1'b1;
        tick_cycle();
        check_eq("stop_valid", out_valid, 0);
        check_eq("stop_busy", busy, 0);
        check_eq("stop_done", done, 0);
        start = 1'b1; len = 8'd5;
        tick_cycle();
        stop = 1'b0; start = 1'b0;
        check_eq("stop_beats_start", busy, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("stop_no_done", done, 0);
            check_eq("stop_no_valid", out_valid, 0);
            tick_cycle();
        end
    endtask

    task automatic reset_test();
        start = 1'b1; mode = 2'd0; seed = 10'h001; len = 8'd20; div = 8'd0; out_ready = 1'b1;
        tick_cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick_cycle();
        check_eq("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", out_valid, 0);
        check_eq("rst_async_data", out_data, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_done", done, 0);
`ifdef PATTERN_GEN_SIG_EN
        check_eq("rst_async_sig", sig, 0);
`endif
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_cycle();
            check_eq("rst_after_done", done, 0);
            check_eq("rst_after_valid", out_valid, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; seed = '0;
        len = '0; div = '0; out_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_data", out_data, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        rst_n = 1'b1;
        tick_cycle();

        run_burst(0, 10'h3FE, 4, 0, 0, 1'b0);
        run_burst(1, 10'h2AB, 12, 2, 0, 1'b1);
        run_burst(2, 10'h000, 3, 2, 2, 1'b0);
        run_burst(2, 10'h000, 3, 0, 2, 1'b0);
        run_burst(3, 10'h0F0, 0, 1, 0, 1'b0);
        run_burst(0, 10'h001, 2, 0, 0, 1'b0);
`ifdef PATTERN_GEN_SIG_EN
        check_eq("sig_directed", sig, 10'h000);
`endif
        stop_test();
        reset_test();

        for (int k = 0; k < 25; k++) begin
            run_burst(int'($urandom_range(0, 3)), 10'($urandom), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
